// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared types and counter helper for the branch predictor
//
// Purpose : 2-bit saturating counter encoding, allocation/reset counter values,
//           and the counter step function used on branch resolution.
// Contents: bp_counter_t, BP_ALLOC_CTR, BP_RESET_CTR, bp_ctr_next()
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_counter_t;

    // A freshly allocated entry predicts taken, but one not-taken flips it.
    localparam bp_counter_t BP_ALLOC_CTR = WEAK_T;
    localparam bp_counter_t BP_RESET_CTR = WEAK_NT;

    // Saturating step: towards STRONG_T when taken, towards STRONG_NT otherwise.
    function automatic bp_counter_t bp_ctr_next(input bp_counter_t ctr, input logic taken);
        bp_counter_t nxt;
        nxt = ctr;
        if (taken) begin
            case (ctr)
                STRONG_NT: nxt = WEAK_NT;
                WEAK_NT:   nxt = WEAK_T;
                WEAK_T:    nxt = STRONG_T;
                default:   nxt = STRONG_T;
            endcase
        end else begin
            case (ctr)
                STRONG_T:  nxt = WEAK_T;
                WEAK_T:    nxt = WEAK_NT;
                WEAK_NT:   nxt = STRONG_NT;
                default:   nxt = STRONG_NT;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, pipeline control and C-stage resolution bundle
//
// Purpose : groups every non-clock/reset signal of the branch predictor.
// Ports   : PC, Stall_R, Stall_C, Flush_R, Flush_C, BranchResolved_C, Taken_C,
//           ActualTarget_C (driven by master); Predict, Prediction,
//           PredictionCorrect_C (driven by slave = predictor).
interface branch_predictor_if #(
    parameter int BIT_COUNT = 32
);
    logic [BIT_COUNT-1:0] PC;
    logic                 Stall_R;
    logic                 Stall_C;
    logic                 Flush_R;
    logic                 Flush_C;
    logic                 BranchResolved_C;
    logic                 Taken_C;
    logic [BIT_COUNT-1:0] ActualTarget_C;
    logic                 Predict;
    logic [BIT_COUNT-1:0] Prediction;
    logic                 PredictionCorrect_C;

    modport master (
        output PC, Stall_R, Stall_C, Flush_R, Flush_C,
        output BranchResolved_C, Taken_C, ActualTarget_C,
        input  Predict, Prediction, PredictionCorrect_C
    );

    modport slave (
        input  PC, Stall_R, Stall_C, Flush_R, Flush_C,
        input  BranchResolved_C, Taken_C, ActualTarget_C,
        output Predict, Prediction, PredictionCorrect_C
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped branch target buffer storage
//
// Purpose : holds {valid, tag, target, ctr} per entry. Combinational lookup port
//           for fetch, combinational read of the update index for the
//           read-modify-write done in the top, synchronous write, sync reset clear.
// Ports   : clk, reset; lk_idx -> lk_valid/lk_tag/lk_target/lk_ctr;
//           up_idx -> up_valid/up_tag/up_target/up_ctr;
//           wr_en, wr_tag, wr_target, wr_ctr (written at up_idx, sets valid).
module branch_target_buffer
    import branch_predictor_pkg::*;
#(
    parameter int BIT_COUNT = 32,
    parameter int ENTRIES   = 16,
    parameter int IDX_BITS  = $clog2(ENTRIES),
    parameter int TAG_BITS  = BIT_COUNT - IDX_BITS - 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_BITS-1:0]  lk_idx,
    output logic                 lk_valid,
    output logic [TAG_BITS-1:0]  lk_tag,
    output logic [BIT_COUNT-1:0] lk_target,
    output bp_counter_t          lk_ctr,
    input  logic [IDX_BITS-1:0]  up_idx,
    output logic                 up_valid,
    output logic [TAG_BITS-1:0]  up_tag,
    output logic [BIT_COUNT-1:0] up_target,
    output bp_counter_t          up_ctr,
    input  logic                 wr_en,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [BIT_COUNT-1:0] wr_target,
    input  bp_counter_t          wr_ctr
);

    logic                 ent_valid  [ENTRIES];
    logic [TAG_BITS-1:0]  ent_tag    [ENTRIES];
    logic [BIT_COUNT-1:0] ent_target [ENTRIES];
    bp_counter_t          ent_ctr    [ENTRIES];

    // Reads return the registered contents, so a same-cycle write to the
    // looked-up index is not visible until the next cycle.
    assign lk_valid  = ent_valid[lk_idx];
    assign lk_tag    = ent_tag[lk_idx];
    assign lk_target = ent_target[lk_idx];
    assign lk_ctr    = ent_ctr[lk_idx];

    assign up_valid  = ent_valid[up_idx];
    assign up_tag    = ent_tag[up_idx];
    assign up_target = ent_target[up_idx];
    assign up_ctr    = ent_ctr[up_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_valid[i]  <= 1'b0;
                ent_tag[i]    <= '0;
                ent_target[i] <= '0;
                ent_ctr[i]    <= BP_RESET_CTR;
            end
        end else if (wr_en) begin
            ent_valid[up_idx]  <= 1'b1;
            ent_tag[up_idx]    <= wr_tag;
            ent_target[up_idx] <= wr_target;
            ent_ctr[up_idx]    <= wr_ctr;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch-stage branch predictor with R/C prediction tracking
//
// Purpose : looks up PC in a direct-mapped BTB to produce Predict/Prediction,
//           carries each prediction through the R and C slots, reports whether
//           the C-stage prediction matched the resolution, and trains the BTB.
// Ports   : clk, reset (sync, active-high); bp (branch_predictor_if.slave):
//           PC, Stall_R/C, Flush_R/C, BranchResolved_C, Taken_C, ActualTarget_C in;
//           Predict, Prediction, PredictionCorrect_C out.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BIT_COUNT = 32,
    parameter int ENTRIES   = 16
) (
    input  logic              clk,
    input  logic              reset,
    branch_predictor_if.slave bp
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = BIT_COUNT - IDX_BITS - 2;

    typedef struct packed {
        logic                 valid;
        logic [BIT_COUNT-1:0] pc;
        logic                 predicted;
        logic [BIT_COUNT-1:0] pred_target;
    } bp_track_t;

    bp_track_t slot_r;
    bp_track_t slot_c;

    logic [IDX_BITS-1:0]  lk_idx;
    logic [TAG_BITS-1:0]  lk_tag_in;
    logic                 lk_valid;
    logic [TAG_BITS-1:0]  lk_tag;
    logic [BIT_COUNT-1:0] lk_target;
    bp_counter_t          lk_ctr;

    logic [IDX_BITS-1:0]  up_idx;
    logic [TAG_BITS-1:0]  up_tag_in;
    logic                 up_valid;
    logic [TAG_BITS-1:0]  up_tag;
    logic [BIT_COUNT-1:0] up_target;
    bp_counter_t          up_ctr;
    logic                 up_hit;

    logic                 upd_fire;
    logic                 wr_en;
    logic [BIT_COUNT-1:0] wr_target;
    bp_counter_t          wr_ctr;

    logic                 predict;
    logic [BIT_COUNT-1:0] prediction;

    // Instructions are word aligned; the low two PC bits never select anything.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.PC[1:0], slot_c.pc[1:0], slot_r.pc[1:0]};

    // ---------------- fetch lookup ----------------
    assign lk_idx    = bp.PC[IDX_BITS+1:2];
    assign lk_tag_in = bp.PC[BIT_COUNT-1:IDX_BITS+2];

    assign predict    = lk_valid && (lk_tag == lk_tag_in) && lk_ctr[1];
    assign prediction = predict ? lk_target : '0;

    assign bp.Predict    = predict;
    assign bp.Prediction = prediction;

    // ---------------- tracking slots ----------------
    // Per slot: reset > flush > stall (hold) > advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_r <= '0;
        end else if (bp.Flush_R) begin
            slot_r <= '0;
        end else if (!bp.Stall_R) begin
            slot_r.valid       <= 1'b1;
            slot_r.pc          <= bp.PC;
            slot_r.predicted   <= predict;
            slot_r.pred_target <= prediction;
        end
    end

    // When R is held but C is free, C takes a bubble; copying a held R would
    // resolve (and train on) the same instruction twice.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_c <= '0;
        end else if (bp.Flush_C) begin
            slot_c <= '0;
        end else if (!bp.Stall_C) begin
            if (bp.Stall_R) begin
                slot_c <= '0;
            end else begin
                slot_c <= slot_r;
            end
        end
    end

    // ---------------- resolution check ----------------
    assign bp.PredictionCorrect_C = bp.BranchResolved_C && slot_c.valid &&
        ((slot_c.predicted && bp.Taken_C && (slot_c.pred_target == bp.ActualTarget_C)) ||
         (!slot_c.predicted && !bp.Taken_C));

    // ---------------- BTB training ----------------
    assign up_idx    = slot_c.pc[IDX_BITS+1:2];
    assign up_tag_in = slot_c.pc[BIT_COUNT-1:IDX_BITS+2];
    assign up_hit    = up_valid && (up_tag == up_tag_in);

    // A stalled C slot retries next cycle, so training waits until it moves on;
    // a flushed C slot never trains.
    assign upd_fire = bp.BranchResolved_C && slot_c.valid && !bp.Stall_C && !bp.Flush_C;

    // Hits always retrain; misses allocate only when taken.
    assign wr_en     = upd_fire && (up_hit || bp.Taken_C);
    assign wr_ctr    = up_hit ? bp_ctr_next(up_ctr, bp.Taken_C) : BP_ALLOC_CTR;
    assign wr_target = (up_hit && !bp.Taken_C) ? up_target : bp.ActualTarget_C;

    branch_target_buffer #(
        .BIT_COUNT (BIT_COUNT),
        .ENTRIES   (ENTRIES),
        .IDX_BITS  (IDX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .lk_idx    (lk_idx),
        .lk_valid  (lk_valid),
        .lk_tag    (lk_tag),
        .lk_target (lk_target),
        .lk_ctr    (lk_ctr),
        .up_idx    (up_idx),
        .up_valid  (up_valid),
        .up_tag    (up_tag),
        .up_target (up_target),
        .up_ctr    (up_ctr),
        .wr_en     (wr_en),
        .wr_tag    (up_tag_in),
        .wr_target (wr_target),
        .wr_ctr    (wr_ctr)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed vector bench for branch_predictor
module tb_branch_predictor;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_predictor_if #(.BIT_COUNT(32)) bp();

    branch_predictor #(
        .BIT_COUNT (32),
        .ENTRIES   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] FILLER = 32'h0000_1000;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        exp_predict;
        logic [31:0] exp_prediction;
        logic        exp_correct;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bp.PC               = FILLER;
        bp.Stall_R          = 1'b0;
        bp.Stall_C          = 1'b0;
        bp.Flush_R          = 1'b0;
        bp.Flush_C          = 1'b0;
        bp.BranchResolved_C = 1'b0;
        bp.Taken_C          = 1'b0;
        bp.ActualTarget_C   = '0;
    endtask

    task automatic lookup(input string name, input logic [31:0] pc,
                          input logic exp_pred, input logic [31:0] exp_target);
        bp.PC = pc;
        #1;
        check({name, "_predict"}, {31'd0, bp.Predict}, {31'd0, exp_pred});
        check({name, "_prediction"}, bp.Prediction, exp_target);
    endtask

    // Fetch pc, let it travel R then C, resolve it in C.
    task automatic fetch_resolve(input string name, input logic [31:0] pc,
                                 input logic taken, input logic [31:0] target,
                                 input logic exp_pred, input logic [31:0] exp_target,
                                 input logic exp_correct);
        lookup(name, pc, exp_pred, exp_target);
        tick();
        bp.PC = FILLER;
        tick();
        bp.BranchResolved_C = 1'b1;
        bp.Taken_C          = taken;
        bp.ActualTarget_C   = target;
        #1;
        check({name, "_correct"}, {31'd0, bp.PredictionCorrect_C}, {31'd0, exp_correct});
        tick();
        bp.BranchResolved_C = 1'b0;
        bp.Taken_C          = 1'b0;
        bp.ActualTarget_C   = '0;
    endtask

    initial begin
        //           pc            tk    target        pred  prediction    correct
        vecs[0]  = '{32'h100, 1'b1, 32'h200, 1'b0, 32'h000, 1'b0}; // cold miss, alloc WeakT
        vecs[1]  = '{32'h100, 1'b0, 32'h000, 1'b1, 32'h200, 1'b0}; // WeakT -> WeakNT
        vecs[2]  = '{32'h100, 1'b0, 32'h000, 1'b0, 32'h000, 1'b1}; // WeakNT -> StrongNT
        vecs[3]  = '{32'h100, 1'b0, 32'h000, 1'b0, 32'h000, 1'b1}; // StrongNT saturates
        vecs[4]  = '{32'h100, 1'b1, 32'h200, 1'b0, 32'h000, 1'b0}; // -> WeakNT
        vecs[5]  = '{32'h100, 1'b1, 32'h200, 1'b0, 32'h000, 1'b0}; // -> WeakT
        vecs[6]  = '{32'h100, 1'b1, 32'h240, 1'b1, 32'h200, 1'b0}; // wrong target, -> StrongT @0x240
        vecs[7]  = '{32'h100, 1'b1, 32'h240, 1'b1, 32'h240, 1'b1}; // new target predicted
        vecs[8]  = '{32'h104, 1'b0, 32'h000, 1'b0, 32'h000, 1'b1}; // miss not-taken: no alloc
        vecs[9]  = '{32'h104, 1'b0, 32'h000, 1'b0, 32'h000, 1'b1}; // still a miss
        vecs[10] = '{32'h140, 1'b1, 32'h300, 1'b0, 32'h000, 1'b0}; // alias of 0x100 evicts it
        vecs[11] = '{32'h100, 1'b1, 32'h240, 1'b0, 32'h000, 1'b0}; // 0x100 now misses, re-evicts
        vecs[12] = '{32'h140, 1'b1, 32'h300, 1'b0, 32'h000, 1'b0}; // 0x140 misses, alloc WeakT

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // First cycle after reset: nothing predicted, C slot empty.
        bp.BranchResolved_C = 1'b1;
        bp.Taken_C          = 1'b0;
        lookup("reset", 32'h100, 1'b0, 32'h0);
        check("reset_correct", {31'd0, bp.PredictionCorrect_C}, 32'd0);
        tick();
        bp.BranchResolved_C = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 13; i++) begin
            fetch_resolve($sformatf("v%0d", i), vecs[i].pc, vecs[i].taken, vecs[i].target,
                          vecs[i].exp_predict, vecs[i].exp_prediction, vecs[i].exp_correct);
        end

        // Stall_C held for 3 cycles on a resolving not-taken: exactly one step WeakT -> WeakNT.
        lookup("stall_pre", 32'h140, 1'b1, 32'h300);
        tick();
        bp.PC = FILLER;
        tick();
        bp.Stall_R          = 1'b1;
        bp.Stall_C          = 1'b1;
        bp.BranchResolved_C = 1'b1;
        bp.Taken_C          = 1'b0;
        for (int s = 0; s < 3; s++) begin
            lookup($sformatf("stall%0d", s), 32'h140, 1'b1, 32'h300);
            check($sformatf("stall%0d_correct", s), {31'd0, bp.PredictionCorrect_C}, 32'd0);
            tick();
        end
        bp.Stall_R = 1'b0;
        bp.Stall_C = 1'b0;
        tick();
        idle_inputs();
        fetch_resolve("post_stall0", 32'h140, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);   // WeakNT -> WeakT
        fetch_resolve("post_stall1", 32'h140, 1'b1, 32'h300, 1'b1, 32'h300, 1'b1); // -> StrongT

        // Flush_C on a resolving slot must not train.
        lookup("flush_c_pre", 32'h140, 1'b1, 32'h300);
        tick();
        bp.PC = FILLER;
        tick();
        bp.BranchResolved_C = 1'b1;
        bp.Taken_C          = 1'b0;
        bp.Flush_C          = 1'b1;
        tick();
        idle_inputs();
        fetch_resolve("post_flush0", 32'h140, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0); // StrongT -> WeakT
        fetch_resolve("post_flush1", 32'h140, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0); // WeakT -> WeakNT
        fetch_resolve("post_flush2", 32'h140, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0); // WeakNT -> WeakT

        // Flush_R drops the instruction before it reaches C.
        bp.PC      = 32'h140;
        bp.Flush_R = 1'b1;
        tick();
        bp.Flush_R = 1'b0;
        bp.PC      = FILLER;
        tick();
        bp.BranchResolved_C = 1'b1;
        bp.Taken_C          = 1'b1;
        bp.ActualTarget_C   = 32'h300;
        #1;
        check("flush_r_correct", {31'd0, bp.PredictionCorrect_C}, 32'd0);
        tick();
        idle_inputs();
        lookup("pre_reset", 32'h140, 1'b1, 32'h300);

        // Mid-operation reset discards the table.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lookup("post_reset", 32'h140, 1'b0, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
